// File: rtl/dbus_interconnect_if.sv
// Bus bundle between the CPU data port, the interconnect and the memory-mapped slaves.
// The master modport is the CPU/slave-model side; the slave modport is the interconnect itself.
interface dbus_interconnect_if #(
    parameter int unsigned NS     = 4,
    parameter int unsigned SLV_AW = 14
);
    logic                 m_wr;
    logic [31:0]          m_waddr;
    logic [31:0]          m_wdata;
    logic [3:0]           m_wstrb;
    logic                 m_rd;
    logic [31:0]          m_raddr;
    logic [31:0]          m_rdata;
    logic                 m_stall;
    logic [NS-1:0]        s_wr;
    logic [SLV_AW-1:0]    s_waddr;
    logic [31:0]          s_wdata;
    logic [3:0]           s_wstrb;
    logic [NS-1:0]        s_rd;
    logic [SLV_AW-1:0]    s_raddr;
    logic [NS*32-1:0]     s_rdata;
    logic [NS-1:0]        s_rvalid;
    logic                 err_clr;
    logic                 err_irq;
    logic [31:0]          err_addr;

    modport master (
        output m_wr, m_waddr, m_wdata, m_wstrb, m_rd, m_raddr, s_rdata, s_rvalid, err_clr,
        input  m_rdata, m_stall, s_wr, s_waddr, s_wdata, s_wstrb, s_rd, s_raddr, err_irq, err_addr
    );

    modport slave (
        input  m_wr, m_waddr, m_wdata, m_wstrb, m_rd, m_raddr, s_rdata, s_rvalid, err_clr,
        output m_rdata, m_stall, s_wr, s_waddr, s_wdata, s_wstrb, s_rd, s_raddr, err_irq, err_addr
    );
endinterface

// File: rtl/dbus_interconnect.sv
// Data-bus interconnect: address decode for writes and reads, stalling read-return mux
// with per-slave valid and timeout, and a sticky error log for unmapped/timed-out accesses.
module dbus_interconnect #(
    parameter int unsigned       NS      = 4,
    parameter int unsigned       BASE_W  = 8,
    parameter logic [NS*32-1:0]  BASES   = {32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000},
    parameter int unsigned       SLV_AW  = 14,
    parameter int unsigned       TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rstn,
    dbus_interconnect_if.slave bus
);
    localparam int unsigned SEL_W        = (NS > 1) ? $clog2(NS) : 1;
    localparam int unsigned CNT_W        = 8;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, UNMAP = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  sel, sel_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [31:0]       rd_addr, rd_addr_nxt;

    logic [NS-1:0]     whit, rhit, wone, rone;
    logic [SEL_W-1:0]  ridx;
    logic              rany;
    logic [31:0]       rdata_arr [NS];
    logic              valid_sel, timeout_hit, accept;
    logic              rd_err, wr_err, err_now;
    logic [31:0]       rd_err_addr, err_new_addr;
    logic [31:0]       rdata;
    logic              stall;
    logic [NS-1:0]     s_rd;
    logic              err_flag;
    logic [31:0]       err_log_addr;

    // Address decode; lowest-index slave wins on overlapping windows
    always_comb begin
        whit = '0;
        rhit = '0;
        wone = '0;
        rone = '0;
        ridx = '0;
        for (int i = 0; i < NS; i++) begin
            whit[i]      = (bus.m_waddr[31 -: BASE_W] == BASES[i*32+31 -: BASE_W]);
            rhit[i]      = (bus.m_raddr[31 -: BASE_W] == BASES[i*32+31 -: BASE_W]);
            rdata_arr[i] = bus.s_rdata[i*32 +: 32];
        end
        for (int i = NS - 1; i >= 0; i--) begin
            if (whit[i]) begin
                wone    = '0;
                wone[i] = 1'b1;
            end
            if (rhit[i]) begin
                rone    = '0;
                rone[i] = 1'b1;
                ridx    = SEL_W'(i);
            end
        end
    end

    assign rany        = |rhit;
    assign valid_sel   = bus.s_rvalid[sel];
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT));
    assign accept      = bus.m_rd & ((state != WAIT) | valid_sel);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            sel     <= '0;
            cnt     <= '0;
            rd_addr <= '0;
        end else begin
            state   <= state_nxt;
            sel     <= sel_nxt;
            cnt     <= cnt_nxt;
            rd_addr <= rd_addr_nxt;
        end
    end

    // Next state: a new read may be accepted in IDLE, UNMAP, or on a WAIT return cycle
    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel;
        cnt_nxt     = cnt;
        rd_addr_nxt = rd_addr;
        rd_err      = 1'b0;
        rd_err_addr = rd_addr;
        case (state)
            WAIT: begin
                if (valid_sel) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    rd_err    = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            IDLE, UNMAP: state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
        if (accept) begin
            if (rany) begin
                state_nxt   = WAIT;
                sel_nxt     = ridx;
                rd_addr_nxt = bus.m_raddr;
                cnt_nxt     = '0;
            end else begin
                state_nxt   = UNMAP;
                rd_err      = 1'b1;
                rd_err_addr = bus.m_raddr;
            end
        end
    end

    // Return mux, stall and read pulse; rdata is zero outside return cycles
    always_comb begin
        rdata = '0;
        stall = 1'b0;
        s_rd  = '0;
        if (state == WAIT) begin
            if (valid_sel)        rdata = rdata_arr[sel];
            else if (timeout_hit) rdata = TIMEOUT_DATA;
            else                  stall = 1'b1;
        end
        if (accept && rany) s_rd = rone;
    end

    assign wr_err       = bus.m_wr & ~(|whit);
    assign err_now      = rd_err | wr_err;
    assign err_new_addr = rd_err ? rd_err_addr : bus.m_waddr;

    // Sticky error log; a fresh error beats a simultaneous clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_flag     <= 1'b0;
            err_log_addr <= '0;
        end else if (err_now && (!err_flag || bus.err_clr)) begin
            err_flag     <= 1'b1;
            err_log_addr <= err_new_addr;
        end else if (bus.err_clr) begin
            err_flag     <= 1'b0;
            err_log_addr <= '0;
        end
    end

    assign bus.s_wr     = {NS{bus.m_wr}} & wone;
    assign bus.s_waddr  = bus.m_waddr[SLV_AW-1:0];
    assign bus.s_wdata  = bus.m_wdata;
    assign bus.s_wstrb  = bus.m_wstrb;
    assign bus.s_rd     = s_rd;
    assign bus.s_raddr  = bus.m_raddr[SLV_AW-1:0];
    assign bus.m_rdata  = rdata;
    assign bus.m_stall  = stall;
    assign bus.err_irq  = err_flag;
    assign bus.err_addr = err_log_addr;
endmodule
